// File: rtl/cache_req_queue.sv
// ---------------------------------------------------------------------------
// cache_req_queue
//
// Buffers CPU load/store requests in a small circular FIFO and issues them to
// a single-ported cache one at a time, in acceptance order. Each request is
// held on the cache strobes until the cache reports done. The result is then
// presented to the CPU as a response and held until the CPU takes it.
//
// Handshakes:
//   req:  a request transfers on a rising edge where req_valid && req_ready.
//         req_ready depends only on the FIFO occupancy and never on a pop in
//         the same cycle.
//   resp: a response transfers on a rising edge where resp_valid &&
//         resp_ready. resp_valid/resp_write/resp_rdata stay stable while
//         resp_valid is high and resp_ready is low.
//   cache: c_read/c_write/c_addr/c_wdata stay stable from issue until the
//         edge where c_done is sampled high. c_done is ignored at all other
//         times.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   CPU request handshake
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   resp_valid/resp_ready CPU response handshake
//   resp_write, resp_rdata response kind and read data (0 for writes)
//   c_addr, c_wdata       address and write data to the cache
//   c_read, c_write       cache strobes (never both high)
//   c_done, c_rdata       cache completion and read data
//   q_count               number of occupied FIFO entries (0..DEPTH)
// ---------------------------------------------------------------------------
module cache_req_queue #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_write,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic [ADDRESS_WIDTH-1:0]  c_addr,
    output logic                      c_read,
    output logic                      c_write,
    output logic [DATA_WIDTH-1:0]     c_wdata,
    input  logic                      c_done,
    input  logic [DATA_WIDTH-1:0]     c_rdata,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ENTRY_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     push;
    logic                     pop;
    logic                     head_write;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_wdata;

    assign req_ready = (count != FULL_COUNT);
    assign push      = req_valid && req_ready;
    // The head is taken into the issue register only from IDLE, so at most
    // one request is ever outstanding to the cache.
    assign pop       = (state == IDLE) && (count != '0);
    assign q_count   = count;

    assign {head_write, head_addr, head_wdata} = mem[rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage. Entries are only read while count > 0, so the array
    // itself needs no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: state register and next-state logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (c_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue register (cache-side outputs) and response register.
    // c_write doubles as the "issued request is a write" flag, which is
    // why it is still valid on the completing edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_addr     <= '0;
            c_wdata    <= '0;
            c_read     <= 1'b0;
            c_write    <= 1'b0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        c_addr  <= head_addr;
                        c_wdata <= head_wdata;
                        c_write <= head_write;
                        c_read  <= !head_write;
                    end
                end
                BUSY: begin
                    if (c_done) begin
                        c_read     <= 1'b0;
                        c_write    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_write <= c_write;
                        resp_rdata <= c_write ? '0 : c_rdata;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    c_read  <= 1'b0;
                    c_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cache_req_queue
//
// Bench for cache_req_queue. A per-cycle step task drives the CPU and cache
// sides and keeps a reference model: a queue of accepted-but-not-issued
// requests, the request currently at the cache, and a queue of expected
// responses {write, rdata}. Scenario tasks configure the drive policy and add
// their own directed checks.
// ---------------------------------------------------------------------------
module tb_cache_req_queue;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] c_addr;
    logic          c_read;
    logic          c_write;
    logic [DW-1:0] c_wdata;
    logic          c_done;
    logic [DW-1:0] c_rdata;
    logic [CW-1:0] q_count;

    cache_req_queue #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata),
        .c_addr    (c_addr),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_wdata   (c_wdata),
        .c_done    (c_done),
        .c_rdata   (c_rdata),
        .q_count   (q_count)
    );

    // ---------------- bookkeeping ----------------
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int push_cyc = 0;
    int resp_cnt = 0;

    // ---------------- drive policy ----------------
    bit            push_always = 1'b1;
    bit            hold_done = 1'b0;
    int            fix_lat = -1;        // <0: random cache latency
    bit            fix_rdata_en = 1'b0;
    logic [DW-1:0] fix_rdata = '0;
    int            rr_mode = 1;         // 0 random, 1 always, 2 never

    // ---------------- reference model / scoreboard ----------------
    req_t          stim_q[$];           // requests still to be offered
    req_t          acc_q[$];            // accepted, not yet issued
    req_t          issued_log[$];       // what the cache saw, as observed
    logic [DW:0]   exp_q[$];            // expected {resp_write, resp_rdata}
    logic [DW:0]   resp_log[$];         // responses taken, as observed
    req_t          cur;
    req_t          push_req;
    bit            busy_m = 1'b0;
    bit            push_pend = 1'b0;
    bit            done_pend = 1'b0;
    bit            resp_acc_pend = 1'b0;
    int            busy_cyc = 0;
    int            lat_tgt = 1;

    function automatic req_t mk_req(logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req_t r;
        r.w = w;
        r.a = a;
        r.d = d;
        return r;
    endfunction

    task automatic model_clear();
        stim_q.delete();
        acc_q.delete();
        exp_q.delete();
        busy_m = 1'b0;
        push_pend = 1'b0;
        done_pend = 1'b0;
        resp_acc_pend = 1'b0;
    endtask

    // One clock: advance, update model from last cycle's drives, check the
    // DUT against the model, then choose the drives for the next edge.
    task automatic step();
        logic [DW-1:0] rd;
        bit rr;
        @(posedge clk);
        #1;
        cyc++;
        if (push_pend) begin
            acc_q.push_back(push_req);
            push_pend = 1'b0;
        end
        if (resp_acc_pend) begin
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL resp_clear: resp_valid=%b expected 0", resp_valid);
            end
            resp_acc_pend = 1'b0;
        end
        if (done_pend) begin
            vectors++;
            if (c_read !== 1'b0 || c_write !== 1'b0 || resp_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL done_to_resp: rd=%b wr=%b resp_valid=%b expected 0 0 1",
                         c_read, c_write, resp_valid);
            end
            done_pend = 1'b0;
            busy_m = 1'b0;
        end
        vectors++;
        if ((c_read && c_write) || (resp_valid && (c_read || c_write))) begin
            miscompares++;
            $display("FAIL strobe_excl: rd=%b wr=%b resp_valid=%b", c_read, c_write, resp_valid);
        end
        if (!busy_m && (c_read || c_write)) begin
            issued_log.push_back(mk_req(c_write, c_addr, c_wdata));
            if (acc_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_issue: addr=%h with nothing queued", c_addr);
            end else begin
                cur = acc_q.pop_front();
                busy_m = 1'b1;
                busy_cyc = 0;
                lat_tgt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(1, 4));
            end
        end
        if (busy_m) begin
            busy_cyc++;
            vectors++;
            if (c_write !== cur.w || c_read !== !cur.w || c_addr !== cur.a || c_wdata !== cur.d) begin
                miscompares++;
                $display("FAIL issue_fields: got w=%b r=%b a=%h d=%h expected w=%b a=%h d=%h",
                         c_write, c_read, c_addr, c_wdata, cur.w, cur.a, cur.d);
            end
        end
        vectors++;
        if (q_count !== CW'(acc_q.size()) || req_ready !== (acc_q.size() != DEPTH)) begin
            miscompares++;
            $display("FAIL occupancy: q_count=%0d req_ready=%b expected %0d %b",
                     q_count, req_ready, acc_q.size(), acc_q.size() != DEPTH);
        end
        if (resp_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_resp: w=%b rdata=%h", resp_write, resp_rdata);
            end else if ({resp_write, resp_rdata} !== exp_q[0]) begin
                miscompares++;
                $display("FAIL resp_data: got %h expected %h", {resp_write, resp_rdata}, exp_q[0]);
            end
        end

        // cache side
        if (busy_m && !hold_done && busy_cyc >= lat_tgt) begin
            rd = fix_rdata_en ? fix_rdata : DW'($urandom);
            c_done = 1'b1;
            c_rdata = rd;
            exp_q.push_back({cur.w, cur.w ? {DW{1'b0}} : rd});
            done_pend = 1'b1;
        end else begin
            // c_done is noise whenever nothing is at the cache
            c_done = busy_m ? 1'b0 : ($urandom_range(0, 3) == 0);
            c_rdata = DW'($urandom);
        end

        // response side
        rr = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        resp_ready = rr;
        if (resp_valid === 1'b1 && rr) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            resp_log.push_back({resp_write, resp_rdata});
            resp_cnt++;
            resp_acc_pend = 1'b1;
        end

        // request side
        if (stim_q.size() > 0 && (push_always || $urandom_range(0, 1) == 1)) begin
            req_valid = 1'b1;
            req_write = stim_q[0].w;
            req_addr  = stim_q[0].a;
            req_wdata = stim_q[0].d;
            if (acc_q.size() != DEPTH) begin
                push_req = stim_q.pop_front();
                push_pend = 1'b1;
                push_cyc = cyc;
            end
        end else begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (!(stim_q.size() == 0 && acc_q.size() == 0 && !busy_m && exp_q.size() == 0 &&
                 !push_pend && !done_pend && !resp_acc_pend) && n < bound) begin
            step();
            n++;
        end
        vectors++;
        if (n >= bound) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d cycles, acc=%0d exp=%0d busy=%b",
                     n, acc_q.size(), exp_q.size(), busy_m);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        vectors++;
        if (q_count !== '0 || c_read !== 1'b0 || c_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: q_count=%0d rd=%b wr=%b expected 0 0 0", q_count, c_read, c_write);
        end
        vectors++;
        if (c_addr !== '0 || c_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_cache_bus: addr=%h wdata=%h expected 0 0", c_addr, c_wdata);
        end
        vectors++;
        if (resp_valid !== 1'b0 || resp_write !== 1'b0 || resp_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_resp: v=%b w=%b d=%h expected 0 0 0", resp_valid, resp_write, resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_single_read();
        int first_cyc = -1;
        int high_cnt = 0;
        bit got = 1'b0;
        logic [DW:0] held;
        fix_lat = 3;
        fix_rdata_en = 1'b1;
        fix_rdata = 32'hDEADBEEF;
        rr_mode = 2;
        push_always = 1'b1;
        hold_done = 1'b0;
        stim_q.push_back(mk_req(1'b0, 8'h14, DW'($urandom)));
        for (int i = 0; i < 30; i++) begin
            step();
            if (c_read === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                high_cnt++;
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (first_cyc != push_cyc + 2) begin
            miscompares++;
            $display("FAIL sr_latency: strobe at cycle %0d expected %0d", first_cyc, push_cyc + 2);
        end
        vectors++;
        if (high_cnt != 3) begin
            miscompares++;
            $display("FAIL sr_strobe_len: %0d cycles expected 3", high_cnt);
        end
        vectors++;
        if (!got || resp_rdata !== 32'hDEADBEEF || resp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL sr_resp: valid=%b w=%b d=%h expected 1 0 deadbeef", got, resp_write, resp_rdata);
        end
        held = {resp_write, resp_rdata};
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (resp_valid !== 1'b1 || {resp_write, resp_rdata} !== held) begin
                miscompares++;
                $display("FAIL sr_hold: v=%b resp=%h expected 1 %h", resp_valid, {resp_write, resp_rdata}, held);
            end
        end
        rr_mode = 1;
        drain(50);
        fix_lat = -1;
        fix_rdata_en = 1'b0;
    endtask

    task automatic test_order();
        fix_rdata_en = 1'b1;
        fix_rdata = 32'h5A5A5A5A;
        rr_mode = 0;
        push_always = 1'b0;
        issued_log.delete();
        resp_log.delete();
        stim_q.push_back(mk_req(1'b1, 8'h08, 32'h11111111));
        stim_q.push_back(mk_req(1'b0, 8'h08, DW'($urandom)));
        stim_q.push_back(mk_req(1'b1, 8'h20, 32'h22222222));
        drain(300);
        vectors++;
        if (issued_log.size() != 3 || resp_log.size() != 3) begin
            miscompares++;
            $display("FAIL ord_count: issued=%0d resps=%0d expected 3 3", issued_log.size(), resp_log.size());
        end else begin
            vectors++;
            if (issued_log[0].w !== 1'b1 || issued_log[0].a !== 8'h08 || issued_log[0].d !== 32'h11111111 ||
                issued_log[1].w !== 1'b0 || issued_log[1].a !== 8'h08 ||
                issued_log[2].w !== 1'b1 || issued_log[2].a !== 8'h20 || issued_log[2].d !== 32'h22222222) begin
                miscompares++;
                $display("FAIL ord_issue: got %h %h %h", issued_log[0], issued_log[1], issued_log[2]);
            end
            vectors++;
            if (resp_log[0] !== {1'b1, 32'h0} || resp_log[1] !== {1'b0, 32'h5A5A5A5A} ||
                resp_log[2] !== {1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL ord_resp: got %h %h %h expected 100000000 05a5a5a5a 100000000",
                         resp_log[0], resp_log[1], resp_log[2]);
            end
        end
        fix_rdata_en = 1'b0;
        rr_mode = 1;
        push_always = 1'b1;
    endtask

    task automatic test_fill();
        int r0;
        int n = 0;
        hold_done = 1'b1;
        push_always = 1'b1;
        rr_mode = 1;
        for (int i = 0; i < 6; i++) begin
            stim_q.push_back(mk_req(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        repeat (12) step();
        vectors++;
        if (q_count !== CW'(DEPTH) || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: q_count=%0d ready=%b expected %0d 0", q_count, req_ready, DEPTH);
        end
        vectors++;
        if (stim_q.size() != 1 || !(c_read || c_write)) begin
            miscompares++;
            $display("FAIL fill_sixth_held: pending=%0d strobe=%b expected 1 1", stim_q.size(), c_read || c_write);
        end
        r0 = resp_cnt;
        hold_done = 1'b0;
        while (stim_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        vectors++;
        if (stim_q.size() != 0 || resp_cnt - r0 < 1) begin
            miscompares++;
            $display("FAIL fill_sixth_after_first: pending=%0d done=%0d expected 0 >=1", stim_q.size(), resp_cnt - r0);
        end
        drain(200);
    endtask

    task automatic test_backpressure();
        logic [DW:0] held;
        int n = 0;
        push_always = 1'b1;
        rr_mode = 2;
        stim_q.push_back(mk_req(1'b0, AW'($urandom), DW'($urandom)));
        while (resp_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        held = {resp_write, resp_rdata};
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back(mk_req(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (resp_valid !== 1'b1 || {resp_write, resp_rdata} !== held || c_read || c_write) begin
                miscompares++;
                $display("FAIL bp_hold: v=%b resp=%h rd=%b wr=%b expected 1 %h 0 0",
                         resp_valid, {resp_write, resp_rdata}, c_read, c_write, held);
            end
        end
        vectors++;
        if (q_count !== CW'(DEPTH) || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_fill: q_count=%0d ready=%b expected %0d 0", q_count, req_ready, DEPTH);
        end
        rr_mode = 1;
        drain(200);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addr_q[$];
        int r0 = resp_cnt;
        logic [AW-1:0] a;
        issued_log.delete();
        rr_mode = 0;
        push_always = 1'b0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            a = AW'($urandom);
            addr_q.push_back(a);
            stim_q.push_back(mk_req(1'b0, a, DW'($urandom)));
        end
        drain(2000);
        vectors++;
        if (resp_cnt - r0 != 3 * DEPTH || issued_log.size() != 3 * DEPTH) begin
            miscompares++;
            $display("FAIL wrap_count: resps=%0d issued=%0d expected %0d", resp_cnt - r0, issued_log.size(), 3 * DEPTH);
        end else begin
            for (int i = 0; i < 3 * DEPTH; i++) begin
                vectors++;
                if (issued_log[i].a !== addr_q[i] || issued_log[i].w !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wrap_order[%0d]: addr=%h w=%b expected %h 0", i, issued_log[i].a, issued_log[i].w, addr_q[i]);
                end
            end
        end
        rr_mode = 1;
        push_always = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        int n = 0;
        hold_done = 1'b1;
        push_always = 1'b1;
        rr_mode = 1;
        for (int i = 0; i < 3; i++) begin
            stim_q.push_back(mk_req(1'($urandom), AW'($urandom), DW'($urandom)));
        end
        while (!(acc_q.size() == 2 && busy_m) && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (q_count !== CW'(2) || !(c_read || c_write)) begin
            miscompares++;
            $display("FAIL rst_setup: q_count=%0d strobe=%b expected 2 1", q_count, c_read || c_write);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        c_done = 1'b0;
        resp_ready = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (c_read !== 1'b0 || c_write !== 1'b0 || q_count !== '0 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: rd=%b wr=%b q_count=%0d resp_valid=%b expected 0 0 0 0",
                     c_read, c_write, q_count, resp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release_ready: req_ready=%b expected 1", req_ready);
        end
        hold_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (resp_valid !== 1'b0 || c_read !== 1'b0 || c_write !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_resp: resp_valid=%b rd=%b wr=%b expected 0 0 0", resp_valid, c_read, c_write);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;
        c_done = 1'b0;
        c_rdata = '0;
        #12;
        test_reset();
        test_single_read();
        test_order();
        test_fill();
        test_backpressure();
        test_wrap();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
